mem_rd_arb: RTL and testbench
=============================

Name: mem_rd_arb

Overview:
- Shares the single DRAM-controller read channel between two requesters: instruction cache (ic) and data cache (dc).
- Picks one requester per free output slot using round-robin, and registers the request toward DRAM.
- Extends the transaction ID with a source bit, and routes each 128-bit fill response back to the requester that issued it.
- Enforces a per-requester cap on outstanding transactions so neither cache can monopolise the DRAM queue.

Parameters:
- XID_BITS, 2, requester-local transaction ID width.
- MAX_OUT, 4, max outstanding (issued, unanswered) reads per requester.
- CNT_W, $clog2(MAX_OUT+1), outstanding-counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ic_addr  in  23  ic line address [26:4]
- ic_xid  in  XID_BITS  ic transaction ID
- ic_re  in  1  ic read request
- ic_ready  out  1  ic request accepted this cycle
- ic_valid  out  1  fill response for ic
- ic_rxid  out  XID_BITS  ID of ic response
- dc_addr, dc_xid, dc_re, dc_ready, dc_valid, dc_rxid: same as the ic_* ports, for dc
- rsp_data  out  128  fill data, shared by both requesters
- mem_addr  out  23  line address to DRAM controller
- mem_xid  out  XID_BITS+1  {src, xid}; src 0=ic, 1=dc
- mem_re  out  1  read request to DRAM controller
- mem_ready  in  1  DRAM controller accepts mem_re this cycle
- mem_valid  in  1  fill response valid
- mem_rxid  in  XID_BITS+1  response ID
- mem_data  in  128  fill data
- err  out  1  sticky protocol error

Behaviour:
- Reset values: mem_re=0, mem_addr=0, mem_xid=0, err=0, both outstanding counters=0, rr pointer "last=dc" (so ic wins the first tie).
- Requester handshake: a transfer happens when x_re && x_ready in the same cycle. While x_re=1 and x_ready=0, the requester holds addr and xid stable. The arbiter never drops a held request.
- Output stage:
  - One register stage drives mem_addr, mem_xid and mem_re.
  - The slot is free when !mem_re || mem_ready.
  - While mem_re && !mem_ready, all three outputs hold unchanged.
- Eligibility: x_elig = x_re && (cnt_x < MAX_OUT).
- Grant: only when the slot is free.
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not granted last.
  - x_ready = grant_x. This is combinational and may depend on mem_ready.
  - On a grant, the next clock edge loads mem_re=1, mem_addr=x_addr, mem_xid={src,x_xid}, and updates the rr pointer.
  - Slot free with no grant: the next edge loads mem_re=0 (mem_addr/mem_xid don't care, but hold).
- Latency and throughput: grant in cycle N gives mem_re=1 in cycle N+1. With mem_ready held at 1, back-to-back grants sustain one request per cycle.
- Outstanding counters, per source:
  - +1 on grant.
  - -1 on mem_valid with mem_rxid[XID_BITS]==src.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT, because eligibility blocks the grant.
- Response routing (combinational, zero latency):
  - ic_valid = mem_valid & ~mem_rxid[XID_BITS]; dc_valid = mem_valid & mem_rxid[XID_BITS].
  - x_rxid = mem_rxid[XID_BITS-1:0].
  - rsp_data = mem_data, unconditionally.
- Error: a response for a source whose counter is 0 sets err=1. That counter stays at 0 (no underflow). err clears only on reset.
- Reset mid-operation:
  - All state returns to reset values and in-flight requests are forgotten.
  - The DRAM controller shares rst_n, so no stale responses are expected. If one arrives anyway, it is still routed and err is set.
- Requests present during reset are not granted; x_ready=0 while rst_n=0.

Decomposition:
- Package mem_pkg holds:
  - mem_addr_t = logic [26:4]
  - mem_src_e {SRC_IC=1'b0, SRC_DC=1'b1}
  - mem_xid_t (XID_BITS+1 wide)
  - default MAX_OUT constant
- One natural sub-module: rr_arb2. It is a 2-way round-robin arbiter taking req[1:0] and an advance enable, producing a one-hot gnt[1:0], and owning the last-grant register.
- Counters, output register and routing stay in mem_rd_arb.

Test Plan:
1. Single ic request: ic_re=1, ic_addr=0x000123, ic_xid=2, mem_ready=1 -> ic_ready=1 in cycle 0; cycle 1 mem_re=1, mem_addr=0x000123, mem_xid=3'b010.
2. Simultaneous ic_re and dc_re held 4 cycles, mem_ready=1 -> mem_xid source sequence ic,dc,ic,dc; each x_ready pulses on alternate cycles.
3. Backpressure: mem_ready=0 for 3 cycles after a grant -> mem_re/mem_addr/mem_xid stable for 3 cycles, ic_ready=dc_ready=0; no lost request once mem_ready=1.
4. Credit limit: ic issues 4 reads with no responses -> 5th ic_re gets ic_ready=0 while dc is still granted. mem_valid with mem_rxid=3'b001 -> ic granted the next free cycle; ic_valid=1, ic_rxid=1.
5. Same-cycle grant and response on ic with cnt_ic=2 -> cnt_ic stays 2. A dc response with cnt_dc=0 -> dc_valid=1, err=1 sticky, cnt_dc stays 0.
6. Reset asserted while mem_re=1 and cnt_ic=3 -> next cycle mem_re=0, counters 0, err=0; first post-reset tie goes to ic.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the DRAM read-channel arbiter: line address, source tag and extended ID.
package mem_pkg;
   localparam int XID_BITS_DEF = 2;
   localparam int MAX_OUT_DEF  = 4;

   typedef logic [26:4] mem_addr_t;
   typedef enum logic {SRC_IC = 1'b0, SRC_DC = 1'b1} mem_src_e;
   typedef logic [XID_BITS_DEF:0] mem_xid_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; combinational one-hot grant, last-grant state updates on adv.
// No backpressure of its own: the caller masks req when it cannot accept a grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);
   logic last_dc;

   always_comb begin
      gnt = req;
      if (&req) gnt = last_dc ? 2'b01 : 2'b10;
   end

   // Resetting to "dc granted last" lets ic win the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n)               last_dc <= 1'b1;
      else if (adv && (|gnt))   last_dc <= gnt[1];
   end
endmodule

// File: rtl/mem_rd_arb.sv
// Shares one DRAM read channel between ic and dc; request is registered (1 cycle), responses route with 0 latency.
// Holds mem_* stable while mem_ready=0; per-source outstanding caps withhold x_ready.
module mem_rd_arb
   import mem_pkg::*;
#(
   parameter int XID_BITS = XID_BITS_DEF,
   parameter int MAX_OUT  = MAX_OUT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  mem_addr_t           ic_addr,
   input  logic [XID_BITS-1:0] ic_xid,
   input  logic                ic_re,
   output logic                ic_ready,
   output logic                ic_valid,
   output logic [XID_BITS-1:0] ic_rxid,
   input  mem_addr_t           dc_addr,
   input  logic [XID_BITS-1:0] dc_xid,
   input  logic                dc_re,
   output logic                dc_ready,
   output logic                dc_valid,
   output logic [XID_BITS-1:0] dc_rxid,
   output logic [127:0]        rsp_data,
   output mem_addr_t           mem_addr,
   output logic [XID_BITS:0]   mem_xid,
   output logic                mem_re,
   input  logic                mem_ready,
   input  logic                mem_valid,
   input  logic [XID_BITS:0]   mem_rxid,
   input  logic [127:0]        mem_data,
   output logic                err
);
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   logic [CNT_W-1:0] cnt_ic, cnt_dc;
   logic [1:0]       req, gnt;
   logic             slot_free, ic_elig, dc_elig, ic_rsp, dc_rsp;

   assign slot_free = !mem_re || mem_ready;
   assign ic_elig   = ic_re && (cnt_ic < MAX_CNT);
   assign dc_elig   = dc_re && (cnt_dc < MAX_CNT);
   assign req       = {dc_elig, ic_elig} & {2{slot_free && rst_n}};

   rr_arb2 u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .adv   (slot_free),
      .gnt   (gnt)
   );

   assign ic_ready = gnt[0];
   assign dc_ready = gnt[1];

   assign ic_rsp   = mem_valid && (mem_rxid[XID_BITS] == SRC_IC);
   assign dc_rsp   = mem_valid && (mem_rxid[XID_BITS] == SRC_DC);
   assign ic_valid = ic_rsp;
   assign dc_valid = dc_rsp;
   assign ic_rxid  = mem_rxid[XID_BITS-1:0];
   assign dc_rxid  = mem_rxid[XID_BITS-1:0];
   assign rsp_data = mem_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_re   <= 1'b0;
         mem_addr <= '0;
         mem_xid  <= '0;
         cnt_ic   <= '0;
         cnt_dc   <= '0;
         err      <= 1'b0;
      end else begin
         if (slot_free) begin
            mem_re <= |gnt;
            if (gnt[0]) begin
               mem_addr <= ic_addr;
               mem_xid  <= {SRC_IC, ic_xid};
            end else if (gnt[1]) begin
               mem_addr <= dc_addr;
               mem_xid  <= {SRC_DC, dc_xid};
            end
         end
         // A grant and a response for the same source cancel out.
         if (gnt[0] && !ic_rsp) cnt_ic <= cnt_ic + CNT_W'(1);
         else if (ic_rsp && !gnt[0]) begin
            if (cnt_ic == '0) err <= 1'b1;
            else              cnt_ic <= cnt_ic - CNT_W'(1);
         end
         if (gnt[1] && !dc_rsp) cnt_dc <= cnt_dc + CNT_W'(1);
         else if (dc_rsp && !gnt[1]) begin
            if (cnt_dc == '0) err <= 1'b1;
            else              cnt_dc <= cnt_dc - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_mem_rd_arb.sv
// Randomized and directed bench for mem_rd_arb against a queue-based reference model.
module tb_mem_rd_arb;
   localparam int MAXO = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [22:0]  ic_addr, dc_addr, mem_addr;
   logic [1:0]   ic_xid, dc_xid, ic_rxid, dc_rxid;
   logic         ic_re, dc_re, ic_ready, dc_ready, ic_valid, dc_valid;
   logic [127:0] rsp_data, mem_data;
   logic [2:0]   mem_xid, mem_rxid;
   logic         mem_re, mem_ready, mem_valid, err;

   mem_rd_arb dut (
      .clk(clk), .rst_n(rst_n),
      .ic_addr(ic_addr), .ic_xid(ic_xid), .ic_re(ic_re), .ic_ready(ic_ready),
      .ic_valid(ic_valid), .ic_rxid(ic_rxid),
      .dc_addr(dc_addr), .dc_xid(dc_xid), .dc_re(dc_re), .dc_ready(dc_ready),
      .dc_valid(dc_valid), .dc_rxid(dc_rxid),
      .rsp_data(rsp_data), .mem_addr(mem_addr), .mem_xid(mem_xid), .mem_re(mem_re),
      .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rxid(mem_rxid),
      .mem_data(mem_data), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   // Reference model: registered request, outstanding IDs per source, tie preference.
   bit          m_re, m_err;
   logic [22:0] m_addr;
   logic [2:0]  m_xid;
   int          cnt[2];
   int          pref;
   int          xq0[$], xq1[$];
   bit          eg0, eg1;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_re = 0; m_err = 0; m_addr = '0; m_xid = '0;
      cnt[0] = 0; cnt[1] = 0; pref = 0;
      xq0.delete(); xq1.delete();
   endtask

   task automatic cycle();
      bit free, e0, e1, inc, dec;
      @(negedge clk);
      free = !m_re || mem_ready;
      e0 = rst_n && ic_re && (cnt[0] < MAXO);
      e1 = rst_n && dc_re && (cnt[1] < MAXO);
      eg0 = free && e0 && (!e1 || pref == 0);
      eg1 = free && e1 && (!e0 || pref == 1);
      chk("ic_ready", ic_ready, eg0);
      chk("dc_ready", dc_ready, eg1);
      chk("mem_re", mem_re, m_re);
      if (m_re) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_xid", mem_xid, m_xid);
      end
      chk("err", err, m_err);
      chk("cnt_ic", dut.cnt_ic, cnt[0]);
      chk("cnt_dc", dut.cnt_dc, cnt[1]);
      chk("ic_valid", ic_valid, mem_valid && !mem_rxid[2]);
      chk("dc_valid", dc_valid, mem_valid && mem_rxid[2]);
      if (mem_valid && !mem_rxid[2]) chk("ic_rxid", ic_rxid, mem_rxid[1:0]);
      if (mem_valid && mem_rxid[2])  chk("dc_rxid", dc_rxid, mem_rxid[1:0]);
      chk("rsp_data", rsp_data, mem_data);
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         if (free) begin
            if (eg0) begin
               m_re = 1; m_addr = ic_addr; m_xid = {1'b0, ic_xid}; pref = 1;
               xq0.push_back(int'(ic_xid));
            end else if (eg1) begin
               m_re = 1; m_addr = dc_addr; m_xid = {1'b1, dc_xid}; pref = 0;
               xq1.push_back(int'(dc_xid));
            end else m_re = 0;
         end
         for (int s = 0; s < 2; s++) begin
            inc = (s == 0) ? eg0 : eg1;
            dec = mem_valid && (int'(mem_rxid[2]) == s);
            if (inc && !dec) cnt[s]++;
            else if (dec && !inc) begin
               if (cnt[s] == 0) m_err = 1;
               else cnt[s]--;
            end
         end
      end
      #1;
   endtask

   // Drive a response for a random outstanding ID; leaves mem_valid=0 if none.
   task automatic pick_rsp();
      int s, idx, x;
      mem_valid = 0;
      if (xq0.size() == 0 && xq1.size() == 0) return;
      if (xq0.size() == 0) s = 1;
      else if (xq1.size() == 0) s = 0;
      else s = int'($urandom_range(0, 1));
      if (s == 0) begin
         idx = int'($urandom_range(0, xq0.size() - 1)); x = xq0[idx]; xq0.delete(idx);
      end else begin
         idx = int'($urandom_range(0, xq1.size() - 1)); x = xq1[idx]; xq1.delete(idx);
      end
      mem_valid = 1;
      mem_rxid  = {s[0], x[1:0]};
      mem_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic drain();
      ic_re = 0; dc_re = 0; mem_ready = 1;
      for (int i = 0; i < 20; i++) begin
         pick_rsp();
         cycle();
      end
      mem_valid = 0;
      cycle();
   endtask

   initial begin
      logic [22:0] held_addr;
      rst_n = 0; ic_re = 0; dc_re = 0; ic_addr = '0; dc_addr = '0; ic_xid = '0; dc_xid = '0;
      mem_ready = 1; mem_valid = 0; mem_rxid = '0; mem_data = '0;
      model_reset();
      #1;
      ic_re = 1; dc_re = 1;
      cycle(); cycle();
      ic_re = 0; dc_re = 0; rst_n = 1;
      chk("rst_mem_addr", mem_addr, 23'h0);
      chk("rst_mem_xid", mem_xid, 3'b000);
      chk("rst_mem_re", mem_re, 1'b0);

      // Single ic request
      ic_re = 1; ic_addr = 23'h000123; ic_xid = 2'd2;
      cycle();
      ic_re = 0;
      chk("t1_mem_re", mem_re, 1'b1);
      chk("t1_mem_addr", mem_addr, 23'h000123);
      chk("t1_mem_xid", mem_xid, 3'b010);
      cycle();

      // Single dc grant so the following tie starts with ic
      dc_re = 1; dc_addr = 23'h0abcde; dc_xid = 2'd1;
      cycle();
      dc_re = 0;
      cycle();

      // Simultaneous requests alternate
      ic_re = 1; dc_re = 1; ic_addr = 23'h111111; dc_addr = 23'h222222; ic_xid = 0; dc_xid = 3;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t2_src", mem_xid[2], i % 2);
      end
      ic_re = 0; dc_re = 0;
      drain();

      // Backpressure holds the output register and withholds ready
      ic_re = 1; ic_addr = 23'h033333; ic_xid = 1;
      cycle();
      held_addr = mem_addr;
      ic_addr = 23'h044444; ic_xid = 2; dc_re = 1; dc_addr = 23'h055555; dc_xid = 0;
      mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_hold_addr", mem_addr, held_addr);
         chk("t3_hold_re", mem_re, 1'b1);
      end
      mem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (eg0) ic_re = 0;
         if (eg1) dc_re = 0;
      end
      ic_re = 0; dc_re = 0;
      drain();

      // Credit limit on ic
      for (int i = 0; i < 4; i++) begin
         ic_re = 1; ic_addr = 23'(i + 16); ic_xid = 2'(i);
         cycle();
      end
      dc_re = 1; dc_addr = 23'h066666; dc_xid = 2;
      cycle();
      chk("t4_dc_granted", mem_xid, 3'b110);
      dc_re = 0;
      mem_valid = 1; mem_rxid = 3'b001; mem_data = {4{32'hdeadbeef}};
      for (int i = 0; i < xq0.size(); i++) if (xq0[i] == 1) begin xq0.delete(i); break; end
      cycle();
      chk("t4_ic_rxid", ic_rxid, 2'd1);
      chk("t4_ic_valid", ic_valid, 1'b1);
      mem_valid = 0;
      cycle();
      chk("t4_ic_regrant", mem_xid[2], 1'b0);
      ic_re = 0;
      drain();

      // Same-cycle grant and response, then an unexpected dc response
      ic_re = 1; ic_xid = 3;
      cycle(); cycle();
      mem_valid = 1; mem_rxid = {1'b0, 2'(xq0[0])}; void'(xq0.pop_front());
      cycle();
      chk("t5_cnt_ic", dut.cnt_ic, 2);
      ic_re = 0; mem_rxid = 3'b100;
      cycle();
      chk("t5_err", err, 1'b1);
      mem_valid = 0;
      cycle(); cycle();
      chk("t5_err_sticky", err, 1'b1);

      // Reset with a held request and three ic outstanding
      ic_re = 1; ic_xid = 0;
      cycle();
      ic_re = 0; mem_ready = 0;
      cycle();
      chk("t6_pre_cnt", dut.cnt_ic, 3);
      rst_n = 0;
      cycle();
      rst_n = 1; mem_ready = 1;
      chk("t6_rst_re", mem_re, 1'b0);
      chk("t6_rst_err", err, 1'b0);
      ic_re = 1; dc_re = 1; ic_addr = 23'h077777; dc_addr = 23'h088888;
      cycle();
      chk("t6_tie_ic", mem_xid[2], 1'b0);
      ic_re = 0; dc_re = 0;
      drain();

      // Random traffic with held requests
      for (int n = 0; n < 400; n++) begin
         if (!ic_re || eg0) begin
            ic_re = ($urandom_range(0, 2) != 0);
            ic_addr = 23'($urandom); ic_xid = 2'($urandom);
         end
         if (!dc_re || eg1) begin
            dc_re = ($urandom_range(0, 2) != 0);
            dc_addr = 23'($urandom); dc_xid = 2'($urandom);
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 4) pick_rsp(); else mem_valid = 0;
         cycle();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
